// File: rtl/usb_slave_pkg.sv
// ============================================================================
// usb_slave_pkg : shared PID, state and endpoint definitions for the USB slave
// Rev 1.0
// ============================================================================
`default_nettype none

package usb_slave_pkg;

   localparam int NUM_EP = 4;

   typedef enum logic [1:0] {
      PID_DATA0 = 2'd0,
      PID_DATA1 = 2'd1,
      PID_NAK   = 2'd2,
      PID_STALL = 2'd3
   } pid_e;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CHECK    = 3'd1,
      S_READ     = 3'd2,
      S_SEND     = 3'd3,
      S_HSHK     = 3'd4,
      S_WAITDONE = 3'd5,
      S_WAITACK  = 3'd6
   } state_e;

   function automatic pid_e data_pid(input logic toggle);
      return toggle ? PID_DATA1 : PID_DATA0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/usb_in_ep_sequencer_if.sv
// ============================================================================
// usb_in_ep_sequencer_if : token, FIFO mux, packet sender and handshake signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface usb_in_ep_sequencer_if;
   logic       tokValid;
   logic [3:0] tokEndP;
   logic [3:0] epEnable;
   logic [3:0] epStall;
   logic [3:0] currEndP;
   logic       TxFifoREn;
   logic [7:0] TxFifoData;
   logic       TxFifoEmpty;
   logic       txReq;
   logic [1:0] txPid;
   logic       txValid;
   logic [7:0] txData;
   logic       txLast;
   logic       txReady;
   logic       txDone;
   logic       ackRcvd;
   logic       ackTimeout;
   logic       busy;

   modport master (
      input  tokValid, tokEndP, epEnable, epStall, TxFifoData, TxFifoEmpty,
             txReady, txDone, ackRcvd, ackTimeout,
      output currEndP, TxFifoREn, txReq, txPid, txValid, txData, txLast, busy
   );

   modport slave (
      output tokValid, tokEndP, epEnable, epStall, TxFifoData, TxFifoEmpty,
             txReady, txDone, ackRcvd, ackTimeout,
      input  currEndP, TxFifoREn, txReq, txPid, txValid, txData, txLast, busy
   );
endinterface

`default_nettype wire

// File: rtl/usb_tx_byte_reg.sv
// ============================================================================
// usb_tx_byte_reg : one-entry payload holding register between FIFO and sender
// Rev 1.0
// ============================================================================
`default_nettype none

module usb_tx_byte_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [7:0] data_o
);

   logic       valid_q;
   logic [7:0] data_q;

   // Data is held after the transfer; only the valid flag drops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= 8'h00;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/usb_in_ep_sequencer.sv
// ============================================================================
// usb_in_ep_sequencer : answers IN tokens on EP0-3 with DATA0/1, NAK or STALL
// Rev 1.0
// ============================================================================
`default_nettype none

module usb_in_ep_sequencer
   import usb_slave_pkg::*;
#(
   parameter int MAX_PKT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   usb_in_ep_sequencer_if.master bus
);

   localparam logic [6:0] LAST_IDX = 7'(MAX_PKT - 1);

   state_e              state_q;
   logic [3:0]          currEndP_q;
   pid_e                txPid_q;
   logic                TxFifoREn_q;
   logic                txReq_q;
   logic                txLast_q;
   logic                rdCap_q;
   logic [6:0]          cnt_q;
   logic [NUM_EP-1:0]   toggle_q;
   logic [NUM_EP-1:0]   toggle_d;

   logic [1:0]          ep;
   logic                byteLoad;
   logic                byteValid;
   logic [7:0]          byteData;
   logic                byteXfer;

   assign ep       = currEndP_q[1:0];
   assign byteLoad = (state_q == S_READ) && rdCap_q;
   assign byteXfer = (state_q == S_SEND) && byteValid && bus.txReady;

   usb_tx_byte_reg u_byte_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (byteLoad),
      .data_i  (bus.TxFifoData),
      .ready_i (bus.txReady),
      .valid_o (byteValid),
      .data_o  (byteData)
   );

   // A disabled endpoint is forced back to DATA0 regardless of any ACK.
   always_comb begin
      toggle_d = toggle_q;
      if ((state_q == S_WAITACK) && bus.ackRcvd) begin
         toggle_d[ep] = ~toggle_q[ep];
      end
      toggle_d = toggle_d & bus.epEnable;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         toggle_q <= '0;
      end else begin
         toggle_q <= toggle_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         currEndP_q  <= 4'd0;
         txPid_q     <= PID_DATA0;
         TxFifoREn_q <= 1'b0;
         txReq_q     <= 1'b0;
         txLast_q    <= 1'b0;
         rdCap_q     <= 1'b0;
         cnt_q       <= 7'd0;
      end else begin
         TxFifoREn_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.tokValid) begin
                  currEndP_q <= bus.tokEndP;
                  state_q    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if ((currEndP_q[3:2] != 2'd0) || !bus.epEnable[ep]) begin
                  state_q <= S_IDLE;
               end else if (bus.epStall[ep]) begin
                  txPid_q <= PID_STALL;
                  txReq_q <= 1'b1;
                  state_q <= S_HSHK;
               end else if (bus.TxFifoEmpty) begin
                  txPid_q <= PID_NAK;
                  txReq_q <= 1'b1;
                  state_q <= S_HSHK;
               end else begin
                  txPid_q     <= data_pid(toggle_q[ep]);
                  txReq_q     <= 1'b1;
                  cnt_q       <= 7'd0;
                  rdCap_q     <= 1'b0;
                  TxFifoREn_q <= 1'b1;
                  state_q     <= S_READ;
               end
            end
            S_HSHK: begin
               if (bus.txDone) begin
                  txReq_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            // First READ cycle strobes the FIFO, second captures its data.
            S_READ: begin
               if (!rdCap_q) begin
                  rdCap_q <= 1'b1;
               end else begin
                  rdCap_q  <= 1'b0;
                  txLast_q <= (cnt_q == LAST_IDX) || bus.TxFifoEmpty;
                  state_q  <= S_SEND;
               end
            end
            S_SEND: begin
               if (byteXfer) begin
                  cnt_q    <= cnt_q + 7'd1;
                  txLast_q <= 1'b0;
                  if (txLast_q) begin
                     state_q <= S_WAITDONE;
                  end else begin
                     TxFifoREn_q <= 1'b1;
                     state_q     <= S_READ;
                  end
               end
            end
            S_WAITDONE: begin
               if (bus.txDone) begin
                  txReq_q <= 1'b0;
                  state_q <= S_WAITACK;
               end
            end
            S_WAITACK: begin
               if (bus.ackRcvd || bus.ackTimeout) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.currEndP  = currEndP_q;
   assign bus.TxFifoREn = TxFifoREn_q;
   assign bus.txReq     = txReq_q;
   assign bus.txPid     = txPid_q;
   assign bus.txValid   = byteValid;
   assign bus.txData    = byteData;
   assign bus.txLast    = txLast_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_usb_in_ep_sequencer.sv
// ============================================================================
// tb_usb_in_ep_sequencer : directed scoreboard bench for usb_in_ep_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_usb_in_ep_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   usb_in_ep_sequencer_if bus ();

   usb_in_ep_sequencer #(.MAX_PKT(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int reCount = 0;
   logic lastSeen = 1'b0;
   logic [8:0] sbq[$];

   logic [7:0] mem [4][128];
   int wp [4] = '{0, 0, 0, 0};
   int rp [4] = '{0, 0, 0, 0};

   // FIFO mux model: data appears the cycle after the read strobe
   assign bus.TxFifoEmpty = (wp[bus.currEndP[1:0]] == rp[bus.currEndP[1:0]]);
   always @(posedge clk) begin
      if (bus.TxFifoREn && !bus.TxFifoEmpty) begin
         bus.TxFifoData <= mem[bus.currEndP[1:0]][rp[bus.currEndP[1:0]]];
         rp[bus.currEndP[1:0]] <= rp[bus.currEndP[1:0]] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte monitor: every accepted byte is compared with the scoreboard head
   always @(negedge clk) begin
      logic [8:0] got;
      logic [8:0] exp;
      #1;
      if (bus.TxFifoREn) reCount++;
      if (rst_n && bus.txValid && bus.txReady) begin
         got = {bus.txLast, bus.txData};
         if (sbq.size() != 0) exp = sbq.pop_front();
         else exp = ~got;
         chk("tx_byte", 32'(got), 32'(exp));
         if (got[8]) lastSeen = 1'b1;
      end
   end

   task automatic load(input int ep, input logic [7:0] b, input logic last);
      mem[ep][wp[ep]] = b;
      wp[ep] = wp[ep] + 1;
      sbq.push_back({last, b});
   endtask

   task automatic start_in(input logic [3:0] ep, input logic exp_req, input logic [1:0] exp_pid);
      lastSeen = 1'b0;
      @(negedge clk);
      bus.tokEndP = ep;
      bus.tokValid = 1'b1;
      @(negedge clk);
      bus.tokValid = 1'b0;
      chk("currEndP", 32'(bus.currEndP), 32'(ep));
      @(negedge clk);
      chk("txReq_start", 32'(bus.txReq), 32'(exp_req));
      if (exp_req) chk("txPid", 32'(bus.txPid), 32'(exp_pid));
      else chk("busy_noresp", 32'(bus.busy), 32'd0);
   endtask

   // hs: 0 = ACK, 1 = timeout, 2 = ACK and timeout together
   task automatic finish_data(input int hs);
      for (int i = 0; i < 400 && !lastSeen; i++) @(negedge clk);
      chk("last_seen", 32'(lastSeen), 32'd1);
      @(negedge clk);
      chk("txReq_hold", 32'(bus.txReq), 32'd1);
      bus.txDone = 1'b1;
      @(negedge clk);
      bus.txDone = 1'b0;
      chk("txReq_drop", 32'(bus.txReq), 32'd0);
      bus.ackRcvd = (hs != 1);
      bus.ackTimeout = (hs != 0);
      @(negedge clk);
      bus.ackRcvd = 1'b0;
      bus.ackTimeout = 1'b0;
      chk("busy_end", 32'(bus.busy), 32'd0);
   endtask

   task automatic finish_hshk();
      @(negedge clk);
      bus.txDone = 1'b1;
      @(negedge clk);
      bus.txDone = 1'b0;
      chk("hshk_txReq", 32'(bus.txReq), 32'd0);
      chk("hshk_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_currEndP"}, 32'(bus.currEndP), 32'd0);
      chk({tag, "_txPid"}, 32'(bus.txPid), 32'd0);
      chk({tag, "_txData"}, 32'(bus.txData), 32'd0);
      chk({tag, "_ren"}, 32'(bus.TxFifoREn), 32'd0);
      chk({tag, "_txReq"}, 32'(bus.txReq), 32'd0);
      chk({tag, "_txValid"}, 32'(bus.txValid), 32'd0);
      chk({tag, "_txLast"}, 32'(bus.txLast), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [7:0] held;
      int rc;
      bus.tokValid = 1'b0;
      bus.tokEndP = 4'd0;
      bus.epEnable = 4'b1111;
      bus.epStall = 4'b0000;
      bus.txReady = 1'b1;
      bus.txDone = 1'b0;
      bus.ackRcvd = 1'b0;
      bus.ackTimeout = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;

      // Normal 3-byte DATA0 packet on EP1, then ACK
      load(1, 8'hA1, 1'b0);
      load(1, 8'hA2, 1'b0);
      load(1, 8'hA3, 1'b1);
      reCount = 0;
      start_in(4'd1, 1'b1, 2'd0);
      finish_data(0);
      chk("ren_count_3", 32'(reCount), 32'd3);

      // 70 bytes on EP2 split into 64 + 6
      for (int i = 0; i < 70; i++) begin
         load(2, 8'(i + 16), ((i == 63) || (i == 69)));
      end
      reCount = 0;
      start_in(4'd2, 1'b1, 2'd0);
      finish_data(0);
      chk("ren_count_64", 32'(reCount), 32'd64);
      reCount = 0;
      start_in(4'd2, 1'b1, 2'd1);
      finish_data(0);
      chk("ren_count_6", 32'(reCount), 32'd6);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      // NAK on empty EP0, STALL on EP3
      reCount = 0;
      start_in(4'd0, 1'b1, 2'd2);
      finish_hshk();
      chk("nak_no_ren", 32'(reCount), 32'd0);
      bus.epStall = 4'b1000;
      start_in(4'd3, 1'b1, 2'd3);
      finish_hshk();
      chk("stall_no_ren", 32'(reCount), 32'd0);
      bus.epStall = 4'b0000;

      // Timeout keeps DATA0; simultaneous ACK and timeout counts as ACK
      load(0, 8'h51, 1'b0);
      load(0, 8'h52, 1'b1);
      start_in(4'd0, 1'b1, 2'd0);
      finish_data(1);
      load(0, 8'h53, 1'b1);
      start_in(4'd0, 1'b1, 2'd0);
      finish_data(2);
      load(0, 8'h54, 1'b1);
      start_in(4'd0, 1'b1, 2'd1);
      finish_data(0);

      // Backpressure on EP3 after the first byte; EP3 still DATA0 after STALL
      load(3, 8'hC1, 1'b0);
      load(3, 8'hC2, 1'b0);
      load(3, 8'hC3, 1'b0);
      load(3, 8'hC4, 1'b1);
      start_in(4'd3, 1'b1, 2'd0);
      for (int i = 0; i < 50 && sbq.size() != 3; i++) @(negedge clk);
      chk("bp_first_byte", 32'(sbq.size()), 32'd3);
      bus.txReady = 1'b0;
      for (int i = 0; i < 50 && !bus.txValid; i++) @(negedge clk);
      chk("bp_valid", 32'(bus.txValid), 32'd1);
      held = bus.txData;
      rc = reCount;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data_stable", 32'(bus.txData), 32'(held));
         chk("bp_no_ren", 32'(reCount), 32'(rc));
      end
      bus.txReady = 1'b1;
      finish_data(0);

      // Disabling EP1 (toggle was DATA1) resets it and silences the endpoint
      bus.epEnable = 4'b1101;
      start_in(4'd1, 1'b0, 2'd0);
      bus.epEnable = 4'b1111;
      load(1, 8'hE1, 1'b1);
      start_in(4'd1, 1'b1, 2'd0);
      finish_data(0);

      // Reset while a byte waits in SEND
      bus.txReady = 1'b0;
      load(2, 8'h71, 1'b0);
      load(2, 8'h72, 1'b0);
      load(2, 8'h73, 1'b1);
      start_in(4'd2, 1'b1, 2'd0);
      for (int i = 0; i < 50 && !bus.txValid; i++) @(negedge clk);
      chk("rst_send_valid", 32'(bus.txValid), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst_n = 1'b1;
      bus.txReady = 1'b1;
      sbq.delete();
      wp[2] = 0;
      @(negedge clk);
      rp[2] = 0;

      // EP1 toggle was DATA1 before reset; reset returns it to DATA0
      load(1, 8'hD1, 1'b1);
      start_in(4'd1, 1'b1, 2'd0);
      finish_data(0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
